// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: address-width derivation and
// elaboration-time parameter sanity checks.
package fifo_pkg;

  function automatic int fifo_addr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic bit fifo_is_pow2(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit fifo_af_ok(input int af, input int depth);
    return (af >= 1) && (af <= depth);
  endfunction

  function automatic bit fifo_ae_ok(input int ae, input int depth);
    return (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bundle for sync_fifo; master = pipeline side, slave = FIFO.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_ENTRIES = 8
);
  localparam int AW = fifo_addr_width(NUM_ENTRIES);

  logic             write_en;
  logic [WIDTH-1:0] write_data;
  logic             full;
  logic             almost_full;
  logic             read_en;
  logic [WIDTH-1:0] read_data;
  logic             empty;
  logic             almost_empty;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  modport master (
    output write_en, write_data, read_en,
    input  full, almost_full, read_data, empty, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  write_en, write_data, read_en,
    output full, almost_full, read_data, empty, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous
// read port, synchronous clear of every word on reset.
module fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) mem_q <= '0;
    else       mem_q <= mem_d;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO using all NUM_ENTRIES slots (wrap-bit pointers).
// Sticky overflow/underflow flops exist only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH                  = 32,
  parameter int NUM_ENTRIES            = 8,
  parameter int ALMOST_FULL_THRESHOLD  = NUM_ENTRIES - 2,
  parameter int ALMOST_EMPTY_THRESHOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  sync_fifo_if.slave  bus
);

  localparam int          AW     = fifo_addr_width(NUM_ENTRIES);
  localparam logic [AW:0] AF_LVL = (AW+1)'(ALMOST_FULL_THRESHOLD);
  localparam logic [AW:0] AE_LVL = (AW+1)'(ALMOST_EMPTY_THRESHOLD);

  if (!fifo_is_pow2(NUM_ENTRIES)) begin : g_bad_depth
    $error("sync_fifo: NUM_ENTRIES must be a power of two >= 2");
  end
  if (!fifo_af_ok(ALMOST_FULL_THRESHOLD, NUM_ENTRIES)) begin : g_bad_af
    $error("sync_fifo: ALMOST_FULL_THRESHOLD out of range 1..NUM_ENTRIES");
  end
  if (!fifo_ae_ok(ALMOST_EMPTY_THRESHOLD, NUM_ENTRIES)) begin : g_bad_ae
    $error("sync_fifo: ALMOST_EMPTY_THRESHOLD out of range 0..NUM_ENTRIES-1");
  end

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count;
  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rdata;

  // Same slot index with opposite wrap bits means every slot is occupied.
  assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign count  = wr_ptr_q - rd_ptr_q;
  assign wr_acc = bus.write_en && !full;
  assign rd_acc = bus.read_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (NUM_ENTRIES),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.write_data),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (rdata)
  );

  assign bus.read_data    = rdata;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.count        = count;
  assign bus.almost_full  = (count >= AF_LVL);
  assign bus.almost_empty = (count <= AE_LVL);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q  | (bus.write_en & full);
    underflow_d = underflow_q | (bus.read_en & empty);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue-based reference model tracks contents
// and sticky flags; a monitor compares every cycle after the clock edge.
module tb_sync_fifo;

  localparam int W = 32;
  localparam int N = 8;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(W), .NUM_ENTRIES(N)) bus ();

  sync_fifo #(
    .WIDTH                  (W),
    .NUM_ENTRIES            (N),
    .ALMOST_FULL_THRESHOLD  (N - 2),
    .ALMOST_EMPTY_THRESHOLD (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mq[$];
  bit           m_ovf, m_unf;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: applies the acceptance rules to an ordinary queue.
  initial begin
    bit rd_ok, wr_ok;
    forever begin
      @(posedge clk);
      if (reset) begin
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end else begin
        if (bus.write_en && mq.size() == N) m_ovf = 1'b1;
        if (bus.read_en && mq.size() == 0)  m_unf = 1'b1;
        rd_ok = bus.read_en && mq.size() > 0;
        wr_ok = bus.write_en && mq.size() < N;
        if (rd_ok) void'(mq.pop_front());
        if (wr_ok) mq.push_back(bus.write_data);
      end
    end
  end

  // Monitor: compares the DUT against the model just after every edge.
  initial begin
    int sz;
    forever begin
      @(posedge clk);
      #1;
      sz = mq.size();
      chk("count",        W'(bus.count),        W'(sz));
      chk("empty",        W'(bus.empty),        W'(sz == 0));
      chk("full",         W'(bus.full),         W'(sz == N));
      chk("almost_full",  W'(bus.almost_full),  W'(sz >= N - 2));
      chk("almost_empty", W'(bus.almost_empty), W'(sz <= 2));
      chk("overflow",     W'(bus.overflow),     W'(ERR_EN & m_ovf));
      chk("underflow",    W'(bus.underflow),    W'(ERR_EN & m_unf));
      if (sz > 0) chk("read_data", bus.read_data, mq[0]);
    end
  end

  task automatic step(input logic we, input logic [W-1:0] wd, input logic re, input logic rst);
    @(negedge clk);
    reset          = rst;
    bus.write_en   = we;
    bus.write_data = wd;
    bus.read_en    = re;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d;
    reset = 1'b1; bus.write_en = 1'b0; bus.read_en = 1'b0; bus.write_data = '0;
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(3);
    #2 chk("reset_read_data", bus.read_data, '0);

    // fill with 0x11..0x88, then drain
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i * 'h11), 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b0);

    // full with both asserted: 0xAA must be dropped
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i * 'h11), 1'b0, 1'b0);
    step(1'b1, 'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1, 1'b0);
    // empty with both asserted: 0x55 accepted, no bypass
    step(1'b1, 'h55, 1'b1, 1'b0);
    #2 chk("empty_both_data", bus.read_data, 'h55);
    step(1'b0, '0, 1'b1, 1'b0);

    // steady stream at occupancy 4, pointers wrap several times
    for (int i = 0; i < 4; i++) step(1'b1, W'('h100 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, W'('h200 + i), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1, 1'b0);

    // error flags: underflow, then overflow, both sticky until reset
    step(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, W'('h300 + i), 1'b0, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1);
    idle(1);

    // reset at count=5 discards everything
    for (int i = 0; i < 5; i++) step(1'b1, W'('h400 + i), 1'b0, 1'b0);
    step(1'b1, 'hDEAD, 1'b1, 1'b1);
    #2 chk("midreset_read_data", bus.read_data, '0);
    step(1'b1, 'h77, 1'b0, 1'b0);
    #2 chk("post_reset_word", bus.read_data, 'h77);
    step(1'b0, '0, 1'b1, 1'b0);
    idle(1);

    // randomized phases with varying write/read bias and rare resets
    for (int ph = 0; ph < 8; ph++) begin
      int wp, rp;
      wp = (ph % 2 == 0) ? 75 : 30;
      rp = (ph % 2 == 0) ? 30 : 75;
      for (int i = 0; i < 60; i++) begin
        d = $urandom;
        step($urandom_range(99) < wp, d, $urandom_range(99) < rp, $urandom_range(99) == 0);
      end
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
